fifo: RTL and testbench



---
 rtl/fifo.sv | 112 +++++++++++
 tb/tb_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// ----------------------------------------------------------------------------
// fifo
//   Single-clock first-word-fall-through FIFO. The producer pushes with enq and
//   the consumer pops with deq. full and empty come straight from the
//   registered pointers. dout always shows the head entry, and it reads zero
//   while the queue is empty.
//
// Parameters
//   WIDTH  data width of din/dout
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low (0 = in reset)
//   enq        enqueue request, din captured when accepted
//   din        write data
//   deq        dequeue request, head removed when accepted
//   full       DEPTH entries stored
//   dout       head-of-queue data (0 when empty)
//   empty      no entries stored
//   overflow   (FIFO_STATUS_EN only) sticky: push attempted while full, no pop
//   underflow  (FIFO_STATUS_EN only) sticky: pop attempted while empty
//
// Build option
//   Define FIFO_STATUS_EN to add the sticky overflow/underflow outputs.
// ----------------------------------------------------------------------------
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq,
  input  logic [WIDTH-1:0] din,
  input  logic             deq,
  output logic             full,
  output logic [WIDTH-1:0] dout,
  output logic             empty
`ifdef FIFO_STATUS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so that full and empty can be told apart
  logic [ADDR_W:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W-1:0] wrIdx, rdIdx;
  logic wrAcc, rdAcc;

  assign wrIdx = wrPtr_q[ADDR_W-1:0];
  assign rdIdx = rdPtr_q[ADDR_W-1:0];

  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrIdx == rdIdx) && (wrPtr_q[ADDR_W] != rdPtr_q[ADDR_W]);

  // A push while full still goes through when a pop frees the head slot in
  // the same cycle. A pop on an empty queue does nothing.
  assign wrAcc = enq & (~full | deq);
  assign rdAcc = deq & ~empty;

  assign dout = empty ? '0 : mem[rdIdx];

  // Next-state pointers. They wrap naturally at 2*DEPTH.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (wrAcc) wrPtr_d = wrPtr_q + (ADDR_W+1)'(1);
    if (rdAcc) rdPtr_d = rdPtr_q + (ADDR_W+1)'(1);
  end

  // Pointer registers. On reset both clear, so the queue is empty at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage array. It has no reset because the pointers alone define which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (wrAcc) mem[wrIdx] <= din;
  end

`ifdef FIFO_STATUS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags. Only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (enq & full & ~deq) overflow_q  <= 1'b1;
      if (deq & empty)       underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk;
  logic             reset;
  logic             enq;
  logic [WIDTH-1:0] din;
  logic             deq;
  logic             full;
  logic [WIDTH-1:0] dout;
  logic             empty;
`ifdef FIFO_STATUS_EN
  logic             overflow;
  logic             underflow;
`endif

  int passed;
  int total;

  // Reference model: the stored contents, oldest entry first
  logic [WIDTH-1:0] model[$];
  bit ovfM;
  bit unfM;

  fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .enq   (enq),
    .din   (din),
    .deq   (deq),
    .full  (full),
    .dout  (dout),
    .empty (empty)
`ifdef FIFO_STATUS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] expHead();
    return (model.size() > 0) ? model[0] : '0;
  endfunction

  // Drives one clock of stimulus and advances the model from the queue rules
  task automatic step(input logic e, input logic [WIDTH-1:0] d, input logic r);
    bit fullM;
    bit emptyM;
    bit wa;
    bit ra;
    fullM  = (model.size() == DEPTH);
    emptyM = (model.size() == 0);
    enq = e;
    din = d;
    deq = r;
    @(posedge clk);
    #1;
    wa = e && (!fullM || r);
    ra = r && !emptyM;
    if (e && fullM && !r) ovfM = 1'b1;
    if (r && emptyM) unfM = 1'b1;
    if (ra) void'(model.pop_front());
    if (wa) model.push_back(d);
    enq = 1'b0;
    deq = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || dout !== '0)
      $display("[TB] FAIL reset_init: empty=%b full=%b dout=%h, need 1 0 00", empty, full, dout);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    total++;
    if (empty !== 1'b0 || dout !== 8'hA1)
      $display("[TB] FAIL pre_reset_fill: empty=%b dout=%h, need 0 a1", empty, dout);
    else passed++;
    // Reset asserted in the middle of a cycle must take effect immediately
    #2;
    reset = 1'b0;
    #1;
    model.delete();
    ovfM = 1'b0;
    unfM = 1'b0;
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || dout !== '0)
      $display("[TB] FAIL reset_async: empty=%b full=%b dout=%h, need 1 0 00", empty, full, dout);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || dout !== '0)
      $display("[TB] FAIL reset_idle: empty=%b full=%b dout=%h, need 1 0 00", empty, full, dout);
    else passed++;
  endtask

  task automatic test_basic_order();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 8'h11;
    vals[1] = 8'h22;
    vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) step(1'b1, vals[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dout !== vals[i] || empty !== 1'b0)
        $display("[TB] FAIL basic_pop%0d: dout=%h empty=%b, need %h 0", i, dout, empty, vals[i]);
      else passed++;
      step(1'b0, 8'h00, 1'b1);
    end
    total++;
    if (empty !== 1'b1 || dout !== '0)
      $display("[TB] FAIL basic_drained: empty=%b dout=%h, need 1 00", empty, dout);
    else passed++;
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (full !== 1'b0)
        $display("[TB] FAIL fill_notfull%0d: full=%b, need 0", i, full);
      else passed++;
      step(1'b1, WIDTH'(i), 1'b0);
    end
    total++;
    if (full !== 1'b1 || empty !== 1'b0)
      $display("[TB] FAIL fill_full: full=%b empty=%b, need 1 0", full, empty);
    else passed++;
    step(1'b1, 8'hAA, 1'b0);
    total++;
    if (full !== 1'b1 || dout !== 8'h00)
      $display("[TB] FAIL fill_drop: full=%b dout=%h, need 1 00", full, dout);
    else passed++;
`ifdef FIFO_STATUS_EN
    total++;
    if (overflow !== ovfM || overflow !== 1'b1)
      $display("[TB] FAIL overflow_flag: overflow=%b, need 1", overflow);
    else passed++;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (dout !== WIDTH'(i) || dout !== expHead())
        $display("[TB] FAIL fill_pop%0d: dout=%h, need %h", i, dout, WIDTH'(i));
      else passed++;
      step(1'b0, 8'h00, 1'b1);
    end
    total++;
    if (empty !== 1'b1 || dout !== '0)
      $display("[TB] FAIL fill_drained: empty=%b dout=%h, need 1 00", empty, dout);
    else passed++;
  endtask

  task automatic test_simultaneous_full();
    logic [WIDTH-1:0] second;
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'($urandom_range(0, 255)), 1'b0);
    second = model[1];
    step(1'b1, 8'h55, 1'b1);
    total++;
    if (full !== 1'b1 || dout !== second)
      $display("[TB] FAIL simul_full: full=%b dout=%h, need 1 %h", full, dout, second);
    else passed++;
    while (model.size() > 0) begin
      total++;
      if (dout !== expHead())
        $display("[TB] FAIL simul_drain: dout=%h, need %h", dout, expHead());
      else passed++;
      if (model.size() == 1) begin
        total++;
        if (dout !== 8'h55)
          $display("[TB] FAIL simul_last: dout=%h, need 55", dout);
        else passed++;
      end
      step(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || dout !== '0)
      $display("[TB] FAIL underflow_empty: empty=%b full=%b dout=%h, need 1 0 00", empty, full, dout);
    else passed++;
`ifdef FIFO_STATUS_EN
    total++;
    if (underflow !== unfM || underflow !== 1'b1)
      $display("[TB] FAIL underflow_flag: underflow=%b, need 1", underflow);
    else passed++;
`endif
    step(1'b1, 8'h7E, 1'b1);
    total++;
    if (empty !== 1'b0 || dout !== 8'h7E)
      $display("[TB] FAIL enq_deq_empty: empty=%b dout=%h, need 0 7e", empty, dout);
    else passed++;
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (empty !== 1'b1)
      $display("[TB] FAIL underflow_drain: empty=%b, need 1", empty);
    else passed++;
  endtask

  task automatic test_wrap();
    int errs;
    logic e;
    logic r;
    errs = 0;
    for (int c = 0; c < 300; c++) begin
      e = ($urandom_range(0, 99) < 60) && (model.size() < DEPTH - 1);
      r = ($urandom_range(0, 99) < 50);
      step(e, WIDTH'($urandom), r);
      total++;
      if (dout !== expHead() || empty !== (model.size() == 0) || full !== (model.size() == DEPTH)) begin
        $display("[TB] FAIL wrap_cycle%0d: dout=%h empty=%b full=%b, need %h %b %b", c, dout, empty,
                 full, expHead(), model.size() == 0, model.size() == DEPTH);
        errs++;
      end else passed++;
    end
    while (model.size() > 0) begin
      total++;
      if (dout !== expHead())
        $display("[TB] FAIL wrap_drain: dout=%h, need %h", dout, expHead());
      else passed++;
      step(1'b0, 8'h00, 1'b1);
    end
`ifdef FIFO_STATUS_EN
    total++;
    if (overflow !== ovfM || underflow !== unfM)
      $display("[TB] FAIL status_sticky: ovf=%b unf=%b, need %b %b", overflow, underflow, ovfM, unfM);
    else passed++;
`endif
  endtask

  initial begin
    passed = 0;
    total  = 0;
    ovfM   = 1'b0;
    unfM   = 1'b0;
    enq    = 1'b0;
    deq    = 1'b0;
    din    = '0;
    reset  = 1'b0;
    test_reset();
    test_basic_order();
    test_fill_full();
    test_simultaneous_full();
    test_underflow();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
